// File: rtl/dma_dev_model_if.sv
// Bus between the ST DMA controller (master) and the FDC/HDC device model (slave):
// register chip select, read/write, address, data in both directions, the
// RDY handshake pair and the sink-side checksum.
interface dma_dev_model_if;
  logic        FCS_N;
  logic        RW;
  logic        A1;
  logic [15:0] DIN;
  logic        RDY_I;
  logic        RDY_O;
  logic [15:0] DOUT;
  logic [15:0] CSUM;

  modport master (output FCS_N, RW, A1, DIN, RDY_I,
                  input  RDY_O, DOUT, CSUM);
  modport slave  (input  FCS_N, RW, A1, DIN, RDY_I,
                  output RDY_O, DOUT, CSUM);
endinterface

// File: rtl/dma_dev_model.sv
// dma_dev_model: bench-side FDC/HDC model behind the ST DMA controller.
// Programmed with a burst count (A1=0) and a command (A1=1, DIN[8] = direction),
// it runs multi-burst transfers separated by clk_en-timed gaps, sourcing a
// counting pattern from DATA_SEED or sinking words from the DMA.
// Optional feature macro: DMA_DEV_CHECKSUM_EN enables the running sum of sunk
// words on CSUM; without it CSUM is tied to zero.
// CNT_W is expected to be 16 or less (count is loaded from DIN).
module dma_dev_model #(
  parameter int unsigned BURST_WORDS = 16,
  parameter int unsigned GAP_TICKS   = 4,
  parameter logic [15:0] DATA_SEED   = 16'h0200,
  parameter int unsigned CNT_W       = 8
) (
  input  logic           clk32,
  input  logic           reset,
  input  logic           clk_en,
  dma_dev_model_if.slave bus
);

  localparam int unsigned        WORDS_W   = 8;
  localparam int unsigned        GAP_W     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [WORDS_W-1:0] LAST_WORD = WORDS_W'(BURST_WORDS - 1);
  localparam logic [GAP_W-1:0]   LAST_GAP  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_XFER, S_GAP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               rdy_d;
  logic               ack;
  logic               cmd_wr;
  logic               cnt_wr;
  logic               reg_rd;
  logic               run;
  logic [CNT_W-1:0]   cnt;
  logic               dir;
  logic [WORDS_W-1:0] words;
  logic [GAP_W-1:0]   gap_cnt;
  logic [15:0]        data;
  logic               rdy_o;
  logic               last_word;
  logic               last_burst;
  logic               gap_done;
  logic               rdy_set;
  logic               rdy_clr;
  logic               word_step;
  logic               burst_end;
  logic               gap_step;

  // Status word seen on a register read: busy, direction, burst count.
  function automatic logic [15:0] status_word(input logic busy, input logic d,
                                              input logic [CNT_W-1:0] c);
    return {busy, d, 6'b000000, 8'(c)};
  endfunction

  assign cmd_wr     = ~bus.FCS_N & ~bus.RW & bus.A1;
  assign cnt_wr     = ~bus.FCS_N & ~bus.RW & ~bus.A1;
  assign reg_rd     = ~bus.FCS_N & bus.RW;
  assign run        = bus.FCS_N;
  assign ack        = bus.RDY_I & ~rdy_d;
  assign last_word  = (words == LAST_WORD);
  // A count rewritten to zero mid-burst is treated like the last burst.
  assign last_burst = (cnt <= CNT_W'(1));
  assign gap_done   = (GAP_TICKS == 0) ? 1'b1 : (clk_en && (gap_cnt == LAST_GAP));

  // Delayed RDY_I for rising-edge acknowledge detection.
  always_ff @(posedge clk32) begin
    if (reset) rdy_d <= 1'b0;
    else       rdy_d <= bus.RDY_I;
  end

  // FSM state register.
  always_ff @(posedge clk32) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: command write always re-arms; otherwise advance only while deselected.
  always_comb begin
    state_nxt = state;
    if (cmd_wr) begin
      state_nxt = S_ARM;
    end else if (run) begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_ARM:   state_nxt = (cnt == '0) ? S_IDLE : S_XFER;
        S_XFER:  if (ack && last_word) state_nxt = last_burst ? S_IDLE : S_GAP;
        S_GAP:   if (gap_done) state_nxt = S_XFER;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: RDY_O set/clear, word and burst strobes, gap tick strobe.
  always_comb begin
    rdy_set   = 1'b0;
    rdy_clr   = 1'b0;
    word_step = 1'b0;
    burst_end = 1'b0;
    gap_step  = 1'b0;
    if (cmd_wr) begin
      rdy_clr = 1'b1;
    end else if (run) begin
      case (state)
        S_IDLE: rdy_clr = clk_en;
        S_ARM: begin
          rdy_set = (cnt != '0);
          rdy_clr = (cnt == '0);
        end
        S_XFER: begin
          if (ack) begin
            word_step = 1'b1;
            burst_end = last_word;
            rdy_clr   = last_word;
          end
        end
        S_GAP: begin
          gap_step = clk_en;
          rdy_set  = gap_done;
        end
        default: rdy_clr = 1'b1;
      endcase
    end
  end

  // Device request line.
  always_ff @(posedge clk32) begin
    if (reset)        rdy_o <= 1'b0;
    else if (rdy_clr) rdy_o <= 1'b0;
    else if (rdy_set) rdy_o <= 1'b1;
  end

  // Direction and remaining-burst count registers.
  always_ff @(posedge clk32) begin
    if (reset) begin
      dir <= 1'b0;
      cnt <= '0;
    end else begin
      if (cmd_wr) dir <= bus.DIN[8];
      if (cnt_wr)         cnt <= bus.DIN[CNT_W-1:0];
      else if (burst_end) cnt <= last_burst ? '0 : cnt - CNT_W'(1);
    end
  end

  // Word position inside the current burst.
  always_ff @(posedge clk32) begin
    if (reset || cmd_wr) words <= '0;
    else if (word_step)  words <= last_word ? '0 : words + WORDS_W'(1);
  end

  // clk_en ticks spent in the inter-burst gap.
  always_ff @(posedge clk32) begin
    if (reset || cmd_wr || burst_end) gap_cnt <= '0;
    else if (gap_step)                gap_cnt <= gap_cnt + GAP_W'(1);
  end

  // Source-direction counting pattern, restarted by every command.
  always_ff @(posedge clk32) begin
    if (reset || cmd_wr)        data <= DATA_SEED;
    else if (word_step && !dir) data <= data + 16'd1;
  end

`ifdef DMA_DEV_CHECKSUM_EN
  logic [15:0] csum;

  // Running modulo-2^16 sum of words sunk from the DMA.
  always_ff @(posedge clk32) begin
    if (reset || cmd_wr)       csum <= '0;
    else if (word_step && dir) csum <= csum + bus.DIN;
  end

  assign bus.CSUM = csum;
`else
  logic unused_din;
  assign unused_din = ^bus.DIN;
  assign bus.CSUM   = 16'h0000;
`endif

  assign bus.RDY_O = rdy_o;
  assign bus.DOUT  = reg_rd ? status_word(state != S_IDLE, dir, cnt) : data;

endmodule
